// File: rtl/cdb_rr_scheduler_pkg.sv
// Shared types and default widths for the round-robin Common Data Bus scheduler.
package CDB_types;

  localparam int ARB_NUM    = 4;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 5;
  localparam int CDB_PREG_W = 6;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  rob_idx;
    logic [CDB_PREG_W-1:0] pd;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;

  // Index width for NUM_REQ units; a single unit still needs a 1-bit field.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_scheduler_if.sv
// Completion-port and broadcast bundle between the functional units and the CDB scheduler.
interface cdb_rr_scheduler_if
  import CDB_types::*;
#(
  parameter int NUM_REQ = ARB_NUM,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int PREG_W  = CDB_PREG_W
);

  localparam int SRC_W = src_width(NUM_REQ);

  logic [NUM_REQ-1:0]             fu_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  fu_rob_idx;
  logic [NUM_REQ-1:0][PREG_W-1:0] fu_pd;
  logic [NUM_REQ-1:0][DATA_W-1:0] fu_data;
  logic [NUM_REQ-1:0]             fu_ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_rob_idx;
  logic [PREG_W-1:0] cdb_pd;
  logic [DATA_W-1:0] cdb_data;
  logic [SRC_W-1:0]  cdb_src;

  modport slave (
    input  fu_valid, fu_rob_idx, fu_pd, fu_data,
    output fu_ready,
    output cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src
  );

  modport master (
    output fu_valid, fu_rob_idx, fu_pd, fu_data,
    input  fu_ready,
    input  cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_rr_scheduler_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping, as one-hot and binary index.
module cdb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_shift;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   rot_oh;
  logic [IDX_W-1:0]     off_term [NUM_REQ];
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       idx_sum;
  logic [IDX_W:0]       idx_wrap;

  // Rotating the doubled vector right by ptr puts unit ptr at bit 0, so
  // plain lowest-set-bit priority becomes round-robin priority.
  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> ptr;
  assign rot       = req_shift[NUM_REQ-1:0];
  assign rot_oh    = rot & (~rot + NUM_REQ'(1));

  // Rotate the one-hot back into unit numbering through the upper half.
  assign gnt_dbl = {rot_oh, rot_oh} << ptr;
  assign gnt     = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  assign any     = |req;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
      assign off_term[gi] = rot_oh[gi] ? IDX_W'(gi) : '0;
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      off = off | off_term[k];
    end
  end

  assign idx_sum  = {1'b0, off} + {1'b0, ptr};
  assign idx_wrap = idx_sum - (IDX_W+1)'(NUM_REQ);
  assign idx      = (idx_sum >= (IDX_W+1)'(NUM_REQ)) ? idx_wrap[IDX_W-1:0] : idx_sum[IDX_W-1:0];

endmodule

// File: rtl/cdb_rr_scheduler.sv
// Round-robin arbiter sharing one registered Common Data Bus among NUM_REQ completion ports.
module cdb_rr_scheduler
  import CDB_types::*;
#(
  parameter int NUM_REQ = ARB_NUM,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int PREG_W  = CDB_PREG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  cdb_rr_scheduler_if.slave  bus
);

  localparam int SRC_W = src_width(NUM_REQ);

  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   rr_ptr_next;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               grant_en;

  logic              cdb_valid_reg;
  logic [TAG_W-1:0]  cdb_rob_idx_reg;
  logic [PREG_W-1:0] cdb_pd_reg;
  logic [DATA_W-1:0] cdb_data_reg;
  logic [SRC_W-1:0]  cdb_src_reg;

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_pick (
    .req (bus.fu_valid),
    .ptr (rr_ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The broadcast stage always accepts, so only reset and flush can block a grant.
  assign grant_en     = rst & ~flush & pick_any;
  assign bus.fu_ready = grant_en ? pick_gnt : '0;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_en) begin
      rr_ptr_next = (pick_idx == SRC_W'(NUM_REQ - 1)) ? '0 : pick_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg      <= '0;
      cdb_valid_reg   <= 1'b0;
      cdb_rob_idx_reg <= '0;
      cdb_pd_reg      <= '0;
      cdb_data_reg    <= '0;
      cdb_src_reg     <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      cdb_valid_reg <= grant_en;
      if (grant_en) begin
        cdb_rob_idx_reg <= bus.fu_rob_idx[pick_idx];
        cdb_pd_reg      <= bus.fu_pd[pick_idx];
        cdb_data_reg    <= bus.fu_data[pick_idx];
        cdb_src_reg     <= pick_idx;
      end
    end
  end

  assign bus.cdb_valid   = cdb_valid_reg;
  assign bus.cdb_rob_idx = cdb_rob_idx_reg;
  assign bus.cdb_pd      = cdb_pd_reg;
  assign bus.cdb_data    = cdb_data_reg;
  assign bus.cdb_src     = cdb_src_reg;

endmodule

// File: tb/tb_cdb_rr_scheduler.sv
// Directed-vector bench for cdb_rr_scheduler with four completion ports.
module tb_cdb_rr_scheduler;
  import CDB_types::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_rr_scheduler_if #(.NUM_REQ(4)) bus ();

  cdb_rr_scheduler #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %-14s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %-14s value=%0h @%0t", tag, got, $time);
    end
  endtask

  task automatic set_pkt(input int i, input cdb_pkt_t p);
    bus.fu_rob_idx[i] = p.rob_idx;
    bus.fu_pd[i]      = p.pd;
    bus.fu_data[i]    = p.data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    flush        = 1'b0;
    bus.fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_pkt(i, '{rob_idx: 5'(10 + i), pd: 6'(20 + i), data: 32'(100 + i)});
    end

    // Reset held with all units requesting
    @(negedge clk);
    chk("rst_ready", 32'(bus.fu_ready), 32'h0);
    chk("rst_valid", 32'(bus.cdb_valid), 32'h0);
    chk("rst_rob", 32'(bus.cdb_rob_idx), 32'h0);
    chk("rst_data", bus.cdb_data, 32'h0);
    chk("rst_src", 32'(bus.cdb_src), 32'h0);
    next_cycle();
    rst = 1'b1;

    // Fairness: all valid from reset -> 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fair_ready", 32'(bus.fu_ready), 32'(1 << (k % 4)));
      chk("fair_valid", 32'(bus.cdb_valid), (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) begin
        chk("fair_src", 32'(bus.cdb_src), 32'((k - 1) % 4));
        chk("fair_rob", 32'(bus.cdb_rob_idx), 32'(10 + (k - 1) % 4));
        chk("fair_data", bus.cdb_data, 32'(100 + (k - 1) % 4));
      end
      next_cycle();
    end
    bus.fu_valid = 4'h0;
    @(negedge clk);
    chk("drain_ready", 32'(bus.fu_ready), 32'h0);
    chk("drain_valid", 32'(bus.cdb_valid), 32'h1);
    chk("drain_src", 32'(bus.cdb_src), 32'h1);
    chk("drain_pd", 32'(bus.cdb_pd), 32'd21);
    next_cycle();
    @(negedge clk);
    chk("idle_valid", 32'(bus.cdb_valid), 32'h0);
    next_cycle();

    // Single requester: unit 2 only, pointer starts at 2
    set_pkt(2, '{rob_idx: 5'd7, pd: 6'd9, data: 32'hDEAD});
    bus.fu_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("one_ready", 32'(bus.fu_ready), 32'b0100);
      chk("one_valid", 32'(bus.cdb_valid), (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) begin
        chk("one_rob", 32'(bus.cdb_rob_idx), 32'd7);
        chk("one_src", 32'(bus.cdb_src), 32'd2);
        chk("one_data", bus.cdb_data, 32'hDEAD);
      end
      next_cycle();
    end
    bus.fu_valid = 4'h0;
    @(negedge clk);
    chk("one_last_vld", 32'(bus.cdb_valid), 32'h1);
    chk("one_last_rob", 32'(bus.cdb_rob_idx), 32'd7);
    next_cycle();

    // Wrap: pointer is 3, units 1 and 3 valid -> 3 then 1
    set_pkt(1, '{rob_idx: 5'd21, pd: 6'd31, data: 32'h1111});
    set_pkt(3, '{rob_idx: 5'd23, pd: 6'd33, data: 32'h3333});
    bus.fu_valid = 4'b1010;
    @(negedge clk);
    chk("wrap_ready3", 32'(bus.fu_ready), 32'b1000);
    next_cycle();
    bus.fu_valid = 4'b0010;
    @(negedge clk);
    chk("wrap_ready1", 32'(bus.fu_ready), 32'b0010);
    chk("wrap_src3", 32'(bus.cdb_src), 32'd3);
    chk("wrap_rob23", 32'(bus.cdb_rob_idx), 32'd23);
    next_cycle();
    bus.fu_valid = 4'hF;
    @(negedge clk);
    chk("wrap_ptr2", 32'(bus.fu_ready), 32'b0100);
    chk("wrap_src1", 32'(bus.cdb_src), 32'd1);
    chk("wrap_rob21", 32'(bus.cdb_rob_idx), 32'd21);
    next_cycle();

    // Flush with units 0 and 1 valid; pointer is 3
    bus.fu_valid = 4'b0011;
    flush        = 1'b1;
    @(negedge clk);
    chk("fl_ready", 32'(bus.fu_ready), 32'h0);
    chk("fl_keep_vld", 32'(bus.cdb_valid), 32'h1);
    chk("fl_keep_src", 32'(bus.cdb_src), 32'd2);
    next_cycle();
    flush = 1'b0;
    set_pkt(0, '{rob_idx: 5'd30, pd: 6'd40, data: 32'hC0DE});
    @(negedge clk);
    chk("fl_resume", 32'(bus.fu_ready), 32'b0001);
    chk("fl_squash", 32'(bus.cdb_valid), 32'h0);
    next_cycle();
    bus.fu_valid = 4'b0010;
    @(negedge clk);
    chk("fl_next", 32'(bus.fu_ready), 32'b0010);
    chk("fl_bc_rob", 32'(bus.cdb_rob_idx), 32'd30);
    chk("fl_bc_data", bus.cdb_data, 32'hC0DE);
    next_cycle();

    // Back-to-back: unit 0 alone, tags 1,2,3
    bus.fu_valid = 4'b0001;
    for (int t = 1; t <= 3; t++) begin
      set_pkt(0, '{rob_idx: 5'(t), pd: 6'(t + 50), data: 32'(t * 16)});
      @(negedge clk);
      chk("b2b_ready", 32'(bus.fu_ready), 32'b0001);
      if (t > 1) begin
        chk("b2b_valid", 32'(bus.cdb_valid), 32'h1);
        chk("b2b_rob", 32'(bus.cdb_rob_idx), 32'(t - 1));
      end
      next_cycle();
    end
    bus.fu_valid = 4'h0;
    @(negedge clk);
    chk("b2b_valid3", 32'(bus.cdb_valid), 32'h1);
    chk("b2b_rob3", 32'(bus.cdb_rob_idx), 32'd3);
    chk("b2b_pd3", 32'(bus.cdb_pd), 32'd53);

    // Asynchronous reset mid-broadcast, pointer currently 1
    #2;
    rst          = 1'b0;
    bus.fu_valid = 4'hF;
    #1;
    chk("arst_valid", 32'(bus.cdb_valid), 32'h0);
    chk("arst_ready", 32'(bus.fu_ready), 32'h0);
    chk("arst_rob", 32'(bus.cdb_rob_idx), 32'h0);
    chk("arst_src", 32'(bus.cdb_src), 32'h0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("arst_ptr0", 32'(bus.fu_ready), 32'b0001);
    chk("arst_idle", 32'(bus.cdb_valid), 32'h0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
